uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single SoC UART transmitter between NREQ byte-stream requesters (e.g. CPU console path, GPIO event reporter, sensor packet formatter). Grants are round-robin and packet-locked, so one requester's frame is never interleaved with another's. Sits between the requesters and the UART core's byte-write interface inside `system`. Guards against stalled or runaway requesters with an idle timeout and a maximum packet length.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_PKT, 16, max bytes per grant before forced release (1..255)
IDLE_TIMEOUT, 1024, cycles a granted requester may hold the lock with req_valid low before forced release (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i]
req_data  in  8*NREQ  packed byte per requester
req_last  in  NREQ  the presented byte ends requester i's packet
req_ready  out  NREQ  byte of requester i accepted this cycle (combinational)
tx_data  out  8  byte to UART, registered
tx_wr  out  1  one-cycle write strobe to UART, registered
tx_busy  in  1  UART transmitting; rises at most 1 cycle after tx_wr
grant  out  NREQ  one-hot current owner, registered; 0 when idle
timeout_err  out  1  one-cycle pulse: lock released by idle timeout
pkt_trunc  out  1  one-cycle pulse: lock released at MAX_PKT without req_last

Behaviour:
- Reset (any cycle, including mid-packet): state IDLE; grant=0, tx_wr=0, tx_data=0, timeout_err=0, pkt_trunc=0; rr pointer=0; counters=0. A byte already in the UART completes; nothing further is written.
- States: IDLE, SEND, HOLD.
- IDLE:
  - If any req_valid: winner = first set bit scanning from pointer upward, wrapping at NREQ.
  - Register grant=onehot(winner) and go to SEND. Byte count and idle count are cleared.
  - No req_ready is asserted in IDLE.
- SEND (g = granted index):
  - req_ready[g] = req_valid[g] & ~tx_busy. All other req_ready bits are 0.
  - On acceptance, next edge: tx_data <= req_data[g], tx_wr <= 1, byte count +1, idle count cleared, go to HOLD.
  - If req_valid[g]=0: idle count +1. On reaching IDLE_TIMEOUT: release, pulse timeout_err, go to IDLE.
- HOLD:
  - Exactly 1 cycle; covers tx_busy latency. tx_wr returns to 0.
  - Release if the accepted byte had req_last, or byte count == MAX_PKT without req_last. The latter also pulses pkt_trunc.
  - Otherwise return to SEND.
- Release:
  - grant <= 0 and pointer <= (g+1) mod NREQ.
  - State goes to IDLE, so the minimum gap between packets is 1 idle cycle.
- Latency: req_valid rising in IDLE at cycle 0 → grant at 1 → req_ready at 1 if UART idle → tx_wr at 2. Sustained throughput is bounded by the UART; the arbiter adds 2 cycles per byte.
- req_valid deasserted by a non-granted requester has no effect. Requesters are expected to hold valid/data until ready.
- Simultaneous events:
  - req_last coinciding with byte count reaching MAX_PKT is a normal end: no pkt_trunc.
  - timeout_err and pkt_trunc are never asserted together.
- Widths:
  - Byte count is $clog2(MAX_PKT+1) bits.
  - Idle count is $clog2(IDLE_TIMEOUT+1) bits, saturating.
  - Pointer is $clog2(NREQ) bits and wraps modulo NREQ, with no out-of-range value for non-power-of-2 NREQ.

Decomposition:
- Shared package uart_arb_pkg holds:
  - the state encoding constants (IDLE, SEND, HOLD);
  - a function for the counter-width calculation.
- One sub-module: rr_pick. It is a combinational round-robin priority picker: inputs req[NREQ] and ptr; outputs onehot[NREQ], idx and any. It is instantiated once in the IDLE path.

Test Plan:
- Single requester: req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), UART idle. Required: grant=0001 at cycle 1, tx_wr at cycles 2,4,6 with data 0x41,0x42,0x43; grant=0 after HOLD, pointer=1.
- Contention: reqs 0,2,3 all valid, 1-byte packets each, pointer=0. Required grant order 0,2,3, then 0 again if still valid; no byte of one requester appears between another's.
- Busy backpressure: tx_busy held high for 50 cycles after the first byte. Required: req_ready stays 0 and tx_wr does not pulse while busy; the second byte is written 1 cycle after busy falls.
- Idle timeout: IDLE_TIMEOUT=8; req 1 sends 1 byte without last, then drops valid. Required: after 8 SEND cycles, timeout_err pulses once and grant goes to 0; a waiting req 2 is granted next.
- Truncation: MAX_PKT=4; req 3 streams 6 bytes without last. Required: 4 tx_wr pulses, pkt_trunc pulse in the 4th HOLD, then re-arbitration. The remaining 2 bytes go in a new grant.
- Reset mid-packet: rst asserted while in HOLD with grant=0100. Required: next edge grant=0, tx_wr=0, pointer=0; after release, req 0 wins ahead of req 2.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and
// counter sizing helper.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2
   } arb_state_e;

   // Bits needed to hold every value 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at NREQ.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] onehot_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   int          k;
   logic [PW-1:0] k_idx;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      k        = 0;
      k_idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         // Explicit wrap keeps the index inside 0..NREQ-1 for any NREQ.
         k = int'(ptr_i) + i;
         if (k >= NREQ) k = k - NREQ;
         k_idx = PW'(k);
         if (!any_o && req_i[k_idx]) begin
            any_o           = 1'b1;
            idx_o           = k_idx;
            onehot_o[k_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART byte-write port
// between NREQ requesters, with idle-timeout and max-length release.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NREQ         = 4,
   parameter  int MAX_PKT      = 16,
   parameter  int IDLE_TIMEOUT = 1024,
   localparam int PW           = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_wr,
   input  logic              tx_busy,
   output logic [NREQ-1:0]   grant,
   output logic              timeout_err,
   output logic              pkt_trunc,
   output logic [1:0]        dbg_state,
   output logic [PW-1:0]     dbg_ptr
);

   localparam int BW = cnt_width(MAX_PKT);
   localparam int IW = cnt_width(IDLE_TIMEOUT);
   localparam logic [BW-1:0] MAX_CNT   = BW'(MAX_PKT);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
   localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_TIMEOUT);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [PW-1:0]   gidx_q, gidx_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [IW-1:0]   icnt_q, icnt_d;
   logic            last_q, last_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_wr_q, tx_wr_d;
   logic            tmo_q, tmo_d;
   logic            trunc_q, trunc_d;
   logic            rel;

   logic [NREQ-1:0] pick_onehot;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            sel_valid, sel_last;
   logic [7:0]      sel_data;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i    (req_valid),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   always_comb begin
      sel_valid = |(req_valid & grant_q);
      sel_last  = |(req_last & grant_q);
      sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_data = sel_data | (req_data[i*8 +: 8] & {8{grant_q[i]}});
      end
   end

   // A byte transfers on a clock edge where req_valid[i] and req_ready[i] are
   // both high; ready is offered only to the owner in SEND while the UART is free.
   assign req_ready = (state_q == ST_SEND && !tx_busy) ? (req_valid & grant_q) : '0;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      ptr_d     = ptr_q;
      bcnt_d    = bcnt_q;
      icnt_d    = icnt_q;
      last_d    = last_q;
      tx_data_d = tx_data_q;
      tx_wr_d   = 1'b0;
      tmo_d     = 1'b0;
      trunc_d   = 1'b0;
      rel       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_onehot;
               gidx_d  = pick_idx;
               bcnt_d  = '0;
               icnt_d  = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (|req_ready) begin
               tx_data_d = sel_data;
               tx_wr_d   = 1'b1;
               bcnt_d    = bcnt_q + 1'b1;
               icnt_d    = '0;
               last_d    = sel_last;
               // Flag truncation while the final allowed byte is in HOLD.
               trunc_d   = !sel_last && ((bcnt_q + 1'b1) == MAX_CNT);
               state_d   = ST_HOLD;
            end else if (!sel_valid) begin
               if (icnt_q != IDLE_SAT) icnt_d = icnt_q + 1'b1;
               if (icnt_q == IDLE_LAST) begin
                  rel   = 1'b1;
                  tmo_d = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (last_q || bcnt_q == MAX_CNT) rel = 1'b1;
            else state_d = ST_SEND;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rel) begin
         grant_d = '0;
         state_d = ST_IDLE;
         ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         ptr_q     <= '0;
         bcnt_q    <= '0;
         icnt_q    <= '0;
         last_q    <= 1'b0;
         tx_data_q <= '0;
         tx_wr_q   <= 1'b0;
         tmo_q     <= 1'b0;
         trunc_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         ptr_q     <= ptr_d;
         bcnt_q    <= bcnt_d;
         icnt_q    <= icnt_d;
         last_q    <= last_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         tmo_q     <= tmo_d;
         trunc_q   <= trunc_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_wr       = tx_wr_q;
   assign grant       = grant_q;
   assign timeout_err = tmo_q;
   assign pkt_trunc   = trunc_q;
   assign dbg_state   = state_q;
   assign dbg_ptr     = ptr_q;

endmodule
